// File: rtl/alu_seq_rv32_pkg.sv
// Shared operation codes and FSM state constants for the sequential RV32-style ALU.
package alu_seq_pkg;

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_XOR   = 4'd2;
    localparam logic [3:0] OP_SLT   = 4'd3;
    localparam logic [3:0] OP_ADD   = 4'd4;
    localparam logic [3:0] OP_SUB   = 4'd5;
    localparam logic [3:0] OP_SLL   = 4'd6;
    localparam logic [3:0] OP_SRL   = 4'd7;
    localparam logic [3:0] OP_SRA   = 4'd8;
    localparam logic [3:0] OP_SLTU  = 4'd9;
    localparam logic [3:0] OP_MUL   = 4'd10;
    localparam logic [3:0] OP_MULHU = 4'd11;
    localparam logic [3:0] OP_DIV   = 4'd12;
    localparam logic [3:0] OP_DIVU  = 4'd13;
    localparam logic [3:0] OP_REM   = 4'd14;
    localparam logic [3:0] OP_REMU  = 4'd15;

    typedef logic [1:0] alu_state_t;

    localparam alu_state_t ST_IDLE = 2'd0;
    localparam alu_state_t ST_BUSY = 2'd1;
    localparam alu_state_t ST_DONE = 2'd2;

endpackage

// File: rtl/alu_seq_rv32_if.sv
// Request/result handshake bundle between a requester (master) and the ALU (slave).
interface alu_seq_rv32_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [3:0]      op_code;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] dout;
    logic            zero_flag;
    logic            sign_out;
    logic            cry_out;

    modport master (
        output in_valid, op1, op2, op_code, out_ready,
        input  in_ready, out_valid, dout, zero_flag, sign_out, cry_out
    );

    modport slave (
        input  in_valid, op1, op2, op_code, out_ready,
        output in_ready, out_valid, dout, zero_flag, sign_out, cry_out
    );
endinterface

// File: rtl/alu_seq_rv32_comb_core.sv
// Single-cycle operations (logic, compare, add/sub, shifts); purely combinational.
module alu_comb_core
    import alu_seq_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [3:0]      op_code_i,
    output logic [XLEN-1:0] res_o,
    output logic            cry_o
);

    logic [XLEN:0]  sum_s;
    logic [XLEN:0]  diff_s;
    logic [SHW-1:0] sh_s;
    logic           lt_s;
    logic           ltu_s;

    assign sum_s  = {1'b0, op1_i} + {1'b0, op2_i};
    assign diff_s = {1'b0, op1_i} - {1'b0, op2_i};
    assign sh_s   = op2_i[SHW-1:0];
    assign lt_s   = ($signed(op1_i) < $signed(op2_i));
    assign ltu_s  = (op1_i < op2_i);

    // Operation select; carry is only meaningful for ADD (carry) and SUB (borrow).
    always_comb begin
        res_o = {XLEN{1'b0}};
        cry_o = 1'b0;
        case (op_code_i)
            OP_AND:  res_o = op1_i & op2_i;
            OP_OR:   res_o = op1_i | op2_i;
            OP_XOR:  res_o = op1_i ^ op2_i;
            OP_SLT:  res_o = {{(XLEN-1){1'b0}}, lt_s};
            OP_ADD:  begin
                res_o = sum_s[XLEN-1:0];
                cry_o = sum_s[XLEN];
            end
            OP_SUB:  begin
                res_o = diff_s[XLEN-1:0];
                cry_o = diff_s[XLEN];
            end
            OP_SLL:  res_o = op1_i << sh_s;
            OP_SRL:  res_o = op1_i >> sh_s;
            OP_SRA:  res_o = $signed(op1_i) >>> sh_s;
            OP_SLTU: res_o = {{(XLEN-1){1'b0}}, ltu_s};
            default: res_o = {XLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/alu_seq_rv32.sv
// Sequential ALU: one-cycle ops via alu_comb_core, bit-serial multiply/divide,
// IDLE/BUSY/DONE handshake FSM and registered result/flags.
module alu_seq_rv32
    import alu_seq_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic          clk,
    input  logic          rst,
    alu_seq_rv32_if.slave bus
);

    localparam logic [SHW:0]    CNT_INIT = (SHW+1)'(XLEN);
    localparam logic [SHW:0]    CNT_ONE  = (SHW+1)'(1);
    localparam logic [XLEN-1:0] ZERO_W   = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONES_W   = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_W    = {1'b1, {(XLEN-1){1'b0}}};

    alu_state_t      state_q, state_d;
    logic [SHW:0]    cnt_q, cnt_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [3:0]      op_q, op_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] aux_q, aux_d;
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic [XLEN-1:0] dout_q;
    logic            zero_q, sign_q, cry_q;

    logic [XLEN-1:0] core_res_s;
    logic            core_cry_s;
    logic            is_iter_s, is_mul_s, is_sdiv_s, is_quo_op_s;
    logic            a_neg_s, b_neg_s, div0_s, ovf_s;
    logic [XLEN-1:0] a_mag_s, b_mag_s, bypass_res_s;
    logic [XLEN:0]   mul_sum_s, div_trial_s;
    logic [XLEN-1:0] mul_hi_s, mul_lo_s, rem_nx_s, quo_nx_s;
    logic [XLEN-1:0] step_acc_s, step_aux_s, iter_res_s;
    logic            load_s, new_cry_s;
    logic [XLEN-1:0] new_res_s;

    alu_comb_core #(.XLEN(XLEN), .SHW(SHW)) u_core (
        .op1_i     (bus.op1),
        .op2_i     (bus.op2),
        .op_code_i (bus.op_code),
        .res_o     (core_res_s),
        .cry_o     (core_cry_s)
    );

    // Request decode: magnitudes for signed divide and the two short-circuit cases.
    always_comb begin
        is_iter_s   = (bus.op_code >= OP_MUL);
        is_mul_s    = (bus.op_code == OP_MUL) || (bus.op_code == OP_MULHU);
        is_sdiv_s   = (bus.op_code == OP_DIV) || (bus.op_code == OP_REM);
        is_quo_op_s = (bus.op_code == OP_DIV) || (bus.op_code == OP_DIVU);
        a_neg_s     = is_sdiv_s & bus.op1[XLEN-1];
        b_neg_s     = is_sdiv_s & bus.op2[XLEN-1];
        a_mag_s     = a_neg_s ? (ZERO_W - bus.op1) : bus.op1;
        b_mag_s     = b_neg_s ? (ZERO_W - bus.op2) : bus.op2;
        div0_s      = (bus.op2 == ZERO_W);
        ovf_s       = is_sdiv_s && (bus.op1 == MIN_W) && (bus.op2 == ONES_W);
        if (div0_s) begin
            bypass_res_s = is_quo_op_s ? ONES_W : bus.op1;
        end else begin
            bypass_res_s = is_quo_op_s ? bus.op1 : ZERO_W;
        end
    end

    // One iteration: shift-add multiply (acc=high, aux=multiplier/low) or
    // restoring divide (acc=remainder, aux=dividend shifting into quotient).
    always_comb begin
        mul_sum_s   = {1'b0, acc_q} + (aux_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
        mul_hi_s    = mul_sum_s[XLEN:1];
        mul_lo_s    = {mul_sum_s[0], aux_q[XLEN-1:1]};
        div_trial_s = {acc_q, aux_q[XLEN-1]} - {1'b0, opnd_q};
        quo_nx_s    = {aux_q[XLEN-2:0], ~div_trial_s[XLEN]};
        if (div_trial_s[XLEN]) begin
            rem_nx_s = {acc_q[XLEN-2:0], aux_q[XLEN-1]};
        end else begin
            rem_nx_s = div_trial_s[XLEN-1:0];
        end
        if ((op_q == OP_MUL) || (op_q == OP_MULHU)) begin
            step_acc_s = mul_hi_s;
            step_aux_s = mul_lo_s;
        end else begin
            step_acc_s = rem_nx_s;
            step_aux_s = quo_nx_s;
        end
        case (op_q)
            OP_MUL:   iter_res_s = mul_lo_s;
            OP_MULHU: iter_res_s = mul_hi_s;
            OP_DIV,
            OP_DIVU:  iter_res_s = neg_quo_q ? (ZERO_W - quo_nx_s) : quo_nx_s;
            default:  iter_res_s = neg_rem_q ? (ZERO_W - rem_nx_s) : rem_nx_s;
        endcase
    end

    // FSM next state and operand/iteration register updates.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        op_d        = op_q;
        acc_d       = acc_q;
        aux_d       = aux_q;
        opnd_d      = opnd_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        load_s      = 1'b0;
        new_res_s   = core_res_s;
        new_cry_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    op_d       = bus.op_code;
                    in_ready_d = 1'b0;
                    if (!is_iter_s) begin
                        load_s      = 1'b1;
                        new_res_s   = core_res_s;
                        new_cry_s   = core_cry_s;
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                    end else if (!is_mul_s && (div0_s || ovf_s)) begin
                        load_s      = 1'b1;
                        new_res_s   = bypass_res_s;
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d   = ST_BUSY;
                        cnt_d     = CNT_INIT;
                        acc_d     = ZERO_W;
                        aux_d     = is_mul_s ? bus.op2 : a_mag_s;
                        opnd_d    = is_mul_s ? bus.op1 : b_mag_s;
                        neg_quo_d = a_neg_s ^ b_neg_s;
                        neg_rem_d = a_neg_s;
                    end
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            ST_BUSY: begin
                acc_d = step_acc_s;
                aux_d = step_aux_s;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    load_s      = 1'b1;
                    new_res_s   = iter_res_s;
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    // State, datapath and result registers; flags change only when a result loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {(SHW+1){1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            op_q        <= 4'd0;
            acc_q       <= ZERO_W;
            aux_q       <= ZERO_W;
            opnd_q      <= ZERO_W;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            dout_q      <= ZERO_W;
            zero_q      <= 1'b0;
            sign_q      <= 1'b0;
            cry_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            op_q        <= op_d;
            acc_q       <= acc_d;
            aux_q       <= aux_d;
            opnd_q      <= opnd_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            if (load_s) begin
                dout_q <= new_res_s;
                zero_q <= (new_res_s == ZERO_W);
                sign_q <= new_res_s[XLEN-1];
                cry_q  <= new_cry_s;
            end else begin
                dout_q <= dout_q;
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;
    assign bus.zero_flag = zero_q;
    assign bus.sign_out  = sign_q;
    assign bus.cry_out   = cry_q;

endmodule

// File: doc/alu_seq_rv32.md
ALU_SEQ_RV32 -- requirements
Module: alu_seq_rv32

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 8..64, power of two.
REQ-002 SHALL have parameter SHW, default $clog2(XLEN), shift-amount width; derived, not overridden.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 op1, op2  input  XLEN each  operands.
REQ-008 op_code  input  4  operation select, encoding per REQ-013.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 dout  output  XLEN  registered result.
REQ-012 zero_flag, sign_out, cry_out  output  1 each  registered flags for dout.

Function
REQ-013 op_code SHALL decode: 0 AND, 1 OR, 2 XOR, 3 SLT, 4 ADD, 5 SUB, 6 SLL, 7 SRL, 8 SRA, 9 SLTU, 10 MUL (low XLEN), 11 MULHU (high XLEN, unsigned), 12 DIV, 13 DIVU, 14 REM, 15 REMU.
REQ-014 Shifts SHALL use op2[SHW-1:0] as full amount 0..XLEN-1; SRA SHALL replicate op1[XLEN-1].
REQ-015 SLT/SLTU SHALL yield zero-extended 1/0 from signed/unsigned op1<op2.
REQ-016 State machine SHALL have states IDLE, BUSY, DONE; in_ready=1 only in IDLE.
REQ-017 Request SHALL be accepted on a cycle with in_valid & in_ready; operands and op_code captured then.
REQ-018 Ops 0..9: IDLE->DONE; out_valid asserted the cycle after acceptance (latency 1).
REQ-019 Ops 10..15: IDLE->BUSY, iteration counter loaded with XLEN, one bit per cycle (shift-add multiply, restoring divide on magnitudes); BUSY->DONE when counter reaches 1; out_valid asserted exactly XLEN+1 cycles after acceptance.
REQ-020 Signed DIV/REM SHALL negate quotient when operand signs differ and remainder to dividend's sign, applied on the BUSY->DONE transition without extra cycles.
REQ-021 Divide by zero SHALL bypass BUSY (latency 1): quotient all-ones, remainder = op1.
REQ-022 DIV/REM with op1=-2^(XLEN-1), op2=-1 SHALL bypass BUSY (latency 1): quotient = op1, remainder 0.
REQ-023 DONE: dout and flags held stable while out_valid & !out_ready; on out_valid & out_ready SHALL go to IDLE; no new request accepted in that same cycle.
REQ-024 zero_flag SHALL equal (dout==0); sign_out SHALL equal dout[XLEN-1].
REQ-025 cry_out SHALL be bit XLEN of the (XLEN+1)-bit unsigned op1+op2 for ADD, of op1-op2 (borrow) for SUB, 0 for all other ops.
REQ-026 in_valid while not in IDLE SHALL be ignored; no queuing.

Reset
REQ-027 rst SHALL force state IDLE, out_valid 0, dout 0, zero_flag 0, sign_out 0, cry_out 0, counter 0.
REQ-028 rst during BUSY or DONE SHALL discard the operation; no out_valid for it after reset.
REQ-029 in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-030 Package alu_seq_pkg SHALL hold op_code localparams and the state enum.
REQ-031 Single-cycle ops (0..9) SHALL live in one combinational sub-module alu_comb_core; iteration, FSM and registers in alu_seq_rv32.

Verification
REQ-032 ADD 0xFFFFFFFF+0x00000001, out_ready=1 -> out_valid next cycle, dout=0, zero_flag=1, cry_out=1.
REQ-033 SRA 0x80000000 by op2=31; SLL 0x00000001 by 31 -> dout 0xFFFFFFFF and 0x80000000, sign_out=1.
REQ-034 MUL 0xFFFFFFFF*0xFFFFFFFF then MULHU same -> dout 0x00000001 then 0xFFFFFFFE, each at acceptance+33 cycles.
REQ-035 DIV -7/2, REM -7/2, DIVU 7/0, DIV 0x80000000/0xFFFFFFFF -> 0xFFFFFFFD, 0xFFFFFFFF, 0xFFFFFFFF (latency 1), 0x80000000 (latency 1).
REQ-036 DIVU with out_ready=0 for 5 cycles after out_valid -> dout stable, in_ready=0, in_valid ignored; release -> IDLE next cycle.
REQ-037 rst asserted 10 cycles into a DIVU -> IDLE, out_valid 0, no stale result; next ADD 2+3 returns 5.
